// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with synchronous clear sweep after reset.
// Latency: 1 cycle from read address to rd; writes visible next cycle (same cycle with BYPASS).
// Backpressure: none; hold freezes all read output registers, busy=1 while the sweep runs.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   we, wa, wd    write port (enable, address, data)
//   ra            NRD packed read addresses, port k at [k*AW +: AW]
//   hold          1: read output registers keep their value
//   rd            NRD packed registered read data, port k at [k*WIDTH +: WIDTH]
//   busy          clear sweep in progress (writes ignored, reads return 0)
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  // Derived from DEPTH; not meant to be overridden.
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic [NRD*AW-1:0]    ra,
  input  logic                 hold,
  output logic [NRD*WIDTH-1:0] rd,
  output logic                 busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable for non-power-of-two range checks.
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  state_t              state;
  logic [AW-1:0]       cnt;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic                wa_ok;
  logic                wr_valid;
  logic                mem_we;
  logic [AW-1:0]       mem_wa;
  logic [WIDTH-1:0]    mem_wd;
  logic [AW-1:0]       ra_k;
  logic [NRD*WIDTH-1:0] rd_nxt;

  assign busy  = (state == CLEAR);
  assign wa_ok = ({1'b0, wa} < DEPTH_W);

  // A user write that will actually modify the array this cycle.
  assign wr_valid = (state == RUN) && we && wa_ok && !(ZERO_REG && (wa == '0));

  // Single physical write port shared between the clear sweep and user writes,
  // so the array can live in a single-write-port block RAM.
  assign mem_we = !rst && ((state == CLEAR) || wr_valid);
  assign mem_wa = (state == CLEAR) ? cnt : wa;
  assign mem_wd = (state == CLEAR) ? '0 : wd;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Next read data per port: out-of-range / zero register first, then the
  // bypassed write data, otherwise the array contents before this edge's write.
  always_comb begin
    rd_nxt = '0;
    ra_k   = '0;
    for (int k = 0; k < NRD; k++) begin
      ra_k = ra[k*AW +: AW];
      if (!({1'b0, ra_k} < DEPTH_W) || (ZERO_REG && (ra_k == '0))) begin
        rd_nxt[k*WIDTH +: WIDTH] = '0;
      end else if (BYPASS && wr_valid && (wa == ra_k)) begin
        rd_nxt[k*WIDTH +: WIDTH] = wd;
      end else begin
        rd_nxt[k*WIDTH +: WIDTH] = mem[ra_k];
      end
    end
  end

  // Control FSM with the read output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      rd    <= '0;
    end else begin
      case (state)
        CLEAR: begin
          // Reads return 0 during the sweep even when hold is asserted.
          rd <= '0;
          if (cnt == LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        RUN: begin
          if (!hold) begin
            rd <= rd_nxt;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          rd    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives two regfile_mp configurations from shared stimulus and
// compares every port every cycle against a behavioural model, plus directed checks.
// Instance A: defaults (DEPTH 32, NRD 2, ZERO_REG 1, BYPASS 1).
// Instance B: DEPTH 20, NRD 4, ZERO_REG 0, BYPASS 0.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst;
  logic         we;
  logic [4:0]   wa;
  logic [31:0]  wd;
  logic [19:0]  ra;
  logic         hold;

  logic [63:0]  a_rd;
  logic         a_busy;
  logic [127:0] b_rd;
  logic         b_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra   (ra[9:0]),
    .hold (hold),
    .rd   (a_rd),
    .busy (a_busy)
  );

  regfile_mp #(
    .WIDTH(32), .DEPTH(20), .NRD(4), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra   (ra),
    .hold (hold),
    .rd   (b_rd),
    .busy (b_busy)
  );

  // Reference model state: array contents, remaining sweep cycles, expected rd.
  logic [31:0] mmem [2][32];
  int          left [2];
  logic [31:0] mrd  [2][4];
  bit          mvalid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Applies one clock edge of the rules to model instance i. During a sweep every
  // read is 0 and writes are dropped, so the whole array is simply zeroed at reset.
  task automatic model_inst(input int i, input int depth, input int nrd,
                            input bit zr, input bit byp);
    int  a;
    bit  wvalid;
    if (rst) begin
      left[i] = depth;
      for (int j = 0; j < 32; j++) mmem[i][j] = 32'h0;
      for (int k = 0; k < 4; k++)  mrd[i][k]  = 32'h0;
    end else if (left[i] > 0) begin
      left[i] = left[i] - 1;
      for (int k = 0; k < 4; k++) mrd[i][k] = 32'h0;
    end else begin
      wvalid = we && (int'(wa) < depth) && !(zr && wa == 5'd0);
      if (!hold) begin
        for (int k = 0; k < nrd; k++) begin
          a = int'(ra[k*5 +: 5]);
          if (a >= depth || (zr && a == 0))      mrd[i][k] = 32'h0;
          else if (byp && wvalid && int'(wa) == a) mrd[i][k] = wd;
          else                                   mrd[i][k] = mmem[i][a];
        end
      end
      if (wvalid) mmem[i][wa] = wd;
    end
  endtask

  task automatic tick();
    if (rst) mvalid = 1'b1;
    model_inst(0, 32, 2, 1'b1, 1'b1);
    model_inst(1, 20, 4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    if (mvalid) begin
      chk("a_busy", 32'(a_busy), 32'(left[0] > 0));
      chk("b_busy", 32'(b_busy), 32'(left[1] > 0));
      for (int k = 0; k < 2; k++) chk($sformatf("a_rd%0d", k), a_rd[k*32 +: 32], mrd[0][k]);
      for (int k = 0; k < 4; k++) chk($sformatf("b_rd%0d", k), b_rd[k*32 +: 32], mrd[1][k]);
    end
  endtask

  task automatic set_ra(input int p0, input int p1, input int p2, input int p3);
    ra = {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
  endtask

  task automatic do_write(input int addr, input logic [31:0] data);
    we = 1'b1; wa = 5'(addr); wd = data;
    tick();
    we = 1'b0;
  endtask

  initial begin
    int cnt_a;
    int cnt_b;

    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; hold = 1'b0;

    // Reset sweep with writes attempted during it.
    tick();
    rst = 1'b0;
    cnt_a = 32'(a_busy);
    cnt_b = 32'(b_busy);
    for (int c = 0; c < 40; c++) begin
      we = (c < 31); wa = 5'($urandom_range(0, 31)); wd = $urandom;
      tick();
      cnt_a += 32'(a_busy);
      cnt_b += 32'(b_busy);
    end
    we = 1'b0;
    chk("a_busy_len", cnt_a, 32);
    chk("b_busy_len", cnt_b, 20);

    // Every entry of A reads 0 after the sweep.
    for (int j = 0; j < 32; j++) begin
      set_ra(j, 31 - j, 0, 0);
      tick();
      chk("a_sweep_zero", a_rd[31:0], 32'h0);
    end

    // Write then read on both ports; writes to r0.
    do_write(5, 32'hDEADBEEF);
    set_ra(5, 5, 5, 0);
    tick();
    chk("a_r5_p0", a_rd[31:0],  32'hDEADBEEF);
    chk("a_r5_p1", a_rd[63:32], 32'hDEADBEEF);
    chk("b_r5_p2", b_rd[95:64], 32'hDEADBEEF);
    do_write(0, 32'h1234);
    set_ra(0, 0, 0, 0);
    tick();
    chk("a_r0_zero", a_rd[31:0], 32'h0);
    chk("b_r0_plain", b_rd[31:0], 32'h1234);

    // Bypass versus read-first.
    do_write(7, 32'h11);
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; set_ra(7, 0, 0, 0);
    tick();
    we = 1'b0;
    chk("a_bypass", a_rd[31:0], 32'hA5A5A5A5);
    chk("b_readfirst", b_rd[31:0], 32'h11);
    tick();
    chk("b_after_write", b_rd[31:0], 32'hA5A5A5A5);

    // Hold keeps rd while writes still land.
    do_write(9, 32'h55);
    set_ra(9, 0, 0, 0);
    tick();
    chk("a_pre_hold", a_rd[31:0], 32'h55);
    hold = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h99;
    for (int i = 0; i < 3; i++) begin
      set_ra(3 + i, 0, 0, 0);
      tick();
      chk("a_hold", a_rd[31:0], 32'h55);
      chk("b_hold", b_rd[31:0], 32'h55);
    end
    hold = 1'b0; we = 1'b0; set_ra(9, 0, 0, 0);
    tick();
    chk("a_hold_write", a_rd[31:0], 32'h99);

    // Reset re-asserted mid-sweep restarts the sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt_a = 32'(a_busy);
    cnt_b = 32'(b_busy);
    for (int c = 0; c < 40; c++) begin
      tick();
      cnt_a += 32'(a_busy);
      cnt_b += 32'(b_busy);
    end
    chk("a_busy_len2", cnt_a, 32);
    chk("b_busy_len2", cnt_b, 20);

    // Entry 0 is ordinary in B; address 25 is out of range in B.
    do_write(0, 32'h7);
    do_write(25, 32'hBAD);
    set_ra(0, 25, 0, 0);
    tick();
    chk("b_r0", b_rd[31:0], 32'h7);
    chk("b_oor", b_rd[63:32], 32'h0);
    chk("a_r0", a_rd[31:0], 32'h0);
    chk("a_r25", a_rd[63:32], 32'hBAD);

    // Random regression.
    for (int c = 0; c < 10000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      we   = $urandom_range(0, 1) == 1;
      wa   = 5'($urandom_range(0, 31));
      wd   = $urandom;
      ra   = 20'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parameterised multi-read-port register file for the multicycle MIPS datapath and its successors. It has one synchronous write port, NRD registered read ports, optional hardwired-zero entry 0, and optional write-to-read bypass. On reset it sweeps the array clear one entry per cycle, so it maps onto single-write-port block RAM; `busy` flags the sweep. Read outputs act as the datapath's A/B (and further) operand latches, with a `hold` input for stalls.

## Interface
- `WIDTH`, 32, data bits per entry
- `DEPTH`, 32, number of entries (≥2, need not be a power of two); `AW = $clog2(DEPTH)`
- `NRD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1: entry 0 always reads 0 and ignores writes
- `BYPASS`, 1, 1: a same-cycle write to a read address is forwarded to that read output

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `we`  in  1  write enable
- `wa`  in  AW  write address
- `wd`  in  WIDTH  write data
- `ra`  in  NRD*AW  read addresses; port k is bits [k*AW +: AW]
- `hold`  in  1  1: all read output registers keep their value
- `rd`  out  NRD*WIDTH  registered read data; port k is bits [k*WIDTH +: WIDTH]
- `busy`  out  1  clear sweep in progress; writes ignored and reads return 0

## Operation
- States: CLEAR and RUN. Clear counter `cnt` is AW bits wide.
- Reset has priority over everything. While `rst`=1 at an edge: state←CLEAR, cnt←0, every `rd` port←0, no array write.
- CLEAR with `rst`=0: mem[cnt]←0 and cnt←cnt+1. `we` is ignored. Every `rd` port←0, regardless of `hold`.
  - At cnt==DEPTH-1 the state goes to RUN and cnt←0.
- `busy` = (state==CLEAR). It is a registered state decode with no combinational path from inputs.
- RUN, write: if `we`=1 and `wa`<DEPTH and not (ZERO_REG and `wa`==0), then mem[wa]←wd.
- RUN, read port k, when `hold`=0, `rd[k]` is selected in this priority:
  - 0 if `ra[k]`≥DEPTH, or if ZERO_REG and `ra[k]`==0.
  - `wd` if BYPASS, the write is valid this cycle, and `wa`==`ra[k]` (write-first).
  - Otherwise mem[`ra[k]`] before this edge's write (read-first).
- RUN, `hold`=1: every `rd` port keeps its value. Writes still occur.
- Multiple read ports at the same address return identical data.
- With ZERO_REG=0, entry 0 is an ordinary register.

## Timing
- Read latency: 1 cycle. The address sampled at edge t is valid on `rd` after edge t.
- Write: visible to a read sampled at edge t+1. With BYPASS=1 it is also visible to a read sampled at the same edge t.
- Reset sequence:
  - The edge with `rst`=1 drives `busy`=1, `rd`=0.
  - DEPTH further edges with `rst`=0 clear entries 0..DEPTH-1.
  - `busy` falls after the last of those edges. The first write is accepted on the next edge.
- `rst` asserted mid-sweep restarts the sweep from entry 0. Asserted in RUN, it re-enters CLEAR. Array contents are not preserved.
- Output values after reset: `rd`=0 on all ports, `busy`=1. Before the first reset edge, all outputs are undefined.
- Counter wrap: cnt never exceeds DEPTH-1, including for non-power-of-two DEPTH.

## Test plan
- Reset sweep, DEPTH=32:
  - Stimulus: pulse `rst` 1 cycle.
  - Required: `busy`=1 for exactly 32 cycles after the rst edge; `we`=1 during the sweep has no effect.
  - Then read all 32 entries: all return 0.
- Write/read, defaults:
  - Stimulus: write 0xDEADBEEF to r5, next cycle `ra0`=5, `ra1`=5.
  - Required: both ports read 0xDEADBEEF one cycle later.
  - Stimulus: write 0x1234 to r0.
  - Required: r0 still reads 0.
- Bypass:
  - Stimulus: write 0xA5A5A5A5 to r7 in the same cycle as `ra0`=7; r7 previously held 0x11.
  - Required with BYPASS=1: `rd0`=0xA5A5A5A5 next cycle.
  - Required with BYPASS=0: `rd0`=0x11, then 0xA5A5A5A5 on the following read.
- Hold:
  - Stimulus: `rd0`=0x55, raise `hold` 3 cycles while writing 0x99 to the same address and changing `ra0`.
  - Required: `rd0` stays 0x55, and the array write of 0x99 still lands.
- Mid-sweep reset, DEPTH=20, ZERO_REG=0:
  - Stimulus: pulse `rst`, re-assert it 10 cycles later.
  - Required: `busy` stays high 20 cycles after the second reset.
  - Stimulus: write 0x7 to r0 and address 25.
  - Required: r0 reads 7; address 25 write is ignored and reads 0.
- NRD=4 random regression:
  - Stimulus: 10k cycles of random `we`/`wa`/`ra`/`hold`/occasional `rst`.
  - Required: matches a reference model on every port every cycle.
